pipelined_cla_adder: RTL and testbench

//  Parametrised, pipelined carry-look-ahead adder/subtractor; next generation of the 4-bit CLA.

---
 rtl/pipelined_cla_adder.sv | 181 ++++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Parametrised, pipelined carry-look-ahead adder/subtractor. The operands
//   are split into GROUP-bit look-ahead groups. Stage k resolves group k with
//   a flattened CLA, and the group carry ripples to the next stage through a
//   register. A valid/ready handshake on both sides gives one operation per
//   cycle when the consumer is not stalling.
//
// Parameters
//   WIDTH  operand/result width, must be a non-zero multiple of GROUP
//   GROUP  look-ahead group width
//   NSTAGE (local) WIDTH/GROUP = pipeline depth = latency in cycles
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a/b/cin/sub valid this cycle
//   in_ready   block can accept (transfer on in_valid && in_ready)
//   a, b       operands
//   cin        carry-in, add mode only
//   sub        0: a+b+cin, 1: a-b computed as a + ~b + 1 (cin ignored)
//   out_valid  sum/cout/ovf valid
//   out_ready  consumer accepts (transfer on out_valid && out_ready)
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (sub: 1 means no borrow, a >= b unsigned)
//   ovf        two's-complement overflow (carry into MSB ^ carry out of MSB)

module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGE = WIDTH / GROUP;

  // A bad parameter combination stops elaboration with a message.
  if ((GROUP < 1) || (WIDTH < GROUP) || ((WIDTH % GROUP) != 0)) begin : g_param_check
    $fatal(1, "pipelined_cla_adder: WIDTH (%0d) must be a non-zero multiple of GROUP (%0d)",
           WIDTH, GROUP);
  end

  // Stage registers. Element k holds the state after group k was resolved.
  // The last element is the output register.
  logic [NSTAGE-1:0]            v_q;
  logic [NSTAGE-1:0]            c_q;
  logic [NSTAGE-1:0]            m_q;
  logic [NSTAGE-1:0][WIDTH-1:0] a_q;
  logic [NSTAGE-1:0][WIDTH-1:0] b_q;
  logic [NSTAGE-1:0][WIDTH-1:0] s_q;

  // Next-state values for every stage register.
  logic [NSTAGE-1:0]            v_d;
  logic [NSTAGE-1:0]            c_d;
  logic [NSTAGE-1:0]            m_d;
  logic [NSTAGE-1:0][WIDTH-1:0] a_d;
  logic [NSTAGE-1:0][WIDTH-1:0] b_d;
  logic [NSTAGE-1:0][WIDTH-1:0] s_d;

  // Source of stage k is element k of these vectors. Element 0 is the
  // (sub-adjusted) input port. Element k>0 is stage register k-1.
  logic [NSTAGE:0]              v_src;
  logic [NSTAGE:0]              c_src;
  logic [NSTAGE:0][WIDTH-1:0]   a_src;
  logic [NSTAGE:0][WIDTH-1:0]   b_src;
  logic [NSTAGE:0][WIDTH-1:0]   s_src;

  logic [WIDTH-1:0]             b_adj;
  logic                         c0;
  logic                         adv;

  // Subtraction is a + ~b + 1. The forced carry-in replaces cin.
  assign b_adj = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;

  assign v_src = {v_q, in_valid};
  assign c_src = {c_q, c0};
  assign a_src = {a_q, a};
  assign b_src = {b_q, b_adj};
  assign s_src = {s_q, {WIDTH{1'b0}}};

  // The whole pipeline moves together. It advances whenever the output
  // register is empty or being drained. This keeps in_ready free of any
  // path from in_valid.
  assign adv       = !v_q[NSTAGE-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[NSTAGE-1];
  assign sum       = s_q[NSTAGE-1];
  assign cout      = c_q[NSTAGE-1];
  assign ovf       = c_q[NSTAGE-1] ^ m_q[NSTAGE-1];

  // Per-stage group CLA. Each carry is written in its flattened look-ahead
  // form: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c[0]. This keeps the
  // group carry depth constant instead of rippling bit by bit.
  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;
  logic             prop;
  logic             term;

  always_comb begin
    v_d  = '0;
    c_d  = '0;
    m_d  = '0;
    a_d  = '0;
    b_d  = '0;
    s_d  = '0;
    g    = '0;
    p    = '0;
    c    = '0;
    prop = 1'b0;
    term = 1'b0;
    for (int k = 0; k < NSTAGE; k++) begin
      g    = a_src[k][k*GROUP +: GROUP] & b_src[k][k*GROUP +: GROUP];
      p    = a_src[k][k*GROUP +: GROUP] ^ b_src[k][k*GROUP +: GROUP];
      c    = '0;
      c[0] = c_src[k];
      for (int i = 0; i < GROUP; i++) begin
        prop = c_src[k];
        for (int j = 0; j <= i; j++) begin
          prop = prop & p[j];
        end
        c[i+1] = prop;
        for (int j = 0; j <= i; j++) begin
          term = g[j];
          for (int m = j + 1; m <= i; m++) begin
            term = term & p[m];
          end
          c[i+1] = c[i+1] | term;
        end
      end
      v_d[k]                     = v_src[k];
      a_d[k]                     = a_src[k];
      b_d[k]                     = b_src[k];
      s_d[k]                     = s_src[k];
      s_d[k][k*GROUP +: GROUP]   = p ^ c[GROUP-1:0];
      c_d[k]                     = c[GROUP];
      // The carry into the top bit of this group is needed for overflow.
      // It only matters in the last stage.
      m_d[k]                     = c[GROUP-1];
    end
  end

  // Stage registers. They shift together on adv and hold otherwise, so a
  // stalled result stays stable and nothing in flight is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      m_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
    end else if (adv) begin
      v_q <= v_d;
      c_q <= c_d;
      m_q <= m_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
    end
  end

  // Operand bits below the current group are never read again, and neither
  // are the last stage's operands. Synthesis trims them. Folding them here
  // marks them as intentionally dead.
  logic unused_bits;
  assign unused_bits = ^{a_src, b_src, m_q, v_src[NSTAGE], c_src[NSTAGE], s_src[NSTAGE]};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder
//   Directed bench for pipelined_cla_adder with WIDTH=16 and GROUP=4 (four
//   stages). Expected results come from hand-computed constants and from a
//   plain arithmetic reference.

module tb_pipelined_cla_adder;

  localparam int WIDTH  = 16;
  localparam int GROUP  = 4;
  localparam int NSTAGE = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks   = 0;
  int failures = 0;

  // Expected results in flight, packed as {ovf, cout, sum}.
  logic [WIDTH+1:0] expq[$];

  pipelined_cla_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: full-width add for sum and cout, and a 15-bit add
  // for the carry into the MSB.
  function automatic logic [WIDTH+1:0] refModel(input logic [15:0] ra, input logic [15:0] rb,
                                                input logic rcin, input logic rsub);
    logic [15:0] bb;
    logic        cc;
    logic [16:0] full;
    logic [15:0] low;
    bb   = rsub ? ~rb : rb;
    cc   = rsub ? 1'b1 : rcin;
    full = {1'b0, ra} + {1'b0, bb} + {16'd0, cc};
    low  = {1'b0, ra[14:0]} + {1'b0, bb[14:0]} + {15'd0, cc};
    return {low[15] ^ full[16], full[16], full[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] ta, input logic [15:0] tb,
                               input logic tcin, input logic tsub);
    in_valid = v;
    a        = ta;
    b        = tb;
    cin      = tcin;
    sub      = tsub;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResult(input string tag, input logic [WIDTH+1:0] exp);
    checkOutput({tag, "_sum"},  {16'd0, sum},  {16'd0, exp[15:0]});
    checkOutput({tag, "_cout"}, {31'd0, cout}, {31'd0, exp[16]});
    checkOutput({tag, "_ovf"},  {31'd0, ovf},  {31'd0, exp[17]});
  endtask

  // One isolated operation. It checks the latency counted in edges
  // (including the accepting edge) and then the result.
  task automatic runOp(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                       input logic tcin, input logic tsub, input logic [WIDTH+1:0] exp);
    int lat;
    applyStimulus(1'b1, ta, tb, tcin, tsub);
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, NSTAGE);
    checkResult(tag, exp);
    tick();
  endtask

  initial begin
    int               stale;
    int               got;
    int               first_cyc;
    int               last_cyc;
    logic [15:0]      ra;
    logic [15:0]      rb;
    logic             rc;
    logic             rs;
    logic [WIDTH+1:0] e;

    out_ready = 1'b1;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_sum", {16'd0, sum}, 32'd0);
    checkOutput("rst_cout", {31'd0, cout}, 32'd0);
    checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed add/sub vectors with hand-computed {ovf, cout, sum}.
    runOp("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    runOp("add_ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000});
    runOp("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    runOp("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    runOp("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555});

    // Reset mid-stream: three ops in flight, the oldest already at the output.
    applyStimulus(1'b1, 16'h8001, 16'h8001, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h0F0F, 16'h0101, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    checkOutput("midrst_pre_valid", {31'd0, out_valid}, 32'd1);
    checkResult("midrst_pre", {1'b1, 1'b1, 16'h0002});
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkResult("midrst", {1'b0, 1'b0, 16'h0000});
    #3;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) stale++;
    end
    checkOutput("midrst_stale", stale, 0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back stream of random ops with the consumer always ready.
    got       = 0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int cyc = 0; cyc < 256 + 12; cyc++) begin
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
        if (expq.size() == 0) begin
          checkOutput("stream_unexpected", 32'd1, 32'd0);
        end else begin
          checkResult("stream", expq.pop_front());
        end
      end
      if (cyc < 256) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        applyStimulus(1'b1, ra, rb, rc, rs);
        if (in_ready) expq.push_back(refModel(ra, rb, rc, rs));
      end else begin
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      end
      tick();
    end
    checkOutput("stream_count", got, 256);
    checkOutput("stream_span", last_cyc - first_cyc, 255);
    checkOutput("stream_left", expq.size(), 0);
    expq.delete();

    // Backpressure: fill the pipe with the consumer stalled, hold five
    // cycles, then drain while one more op waits at the input.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra = 16'h1000 * 16'(i + 1) + 16'h0011;
      rb = 16'h0101 * 16'(i + 2);
      applyStimulus(1'b1, ra, rb, 1'b0, i[0]);
      checkOutput("bp_fill_ready", {31'd0, in_ready}, 32'd1);
      expq.push_back(refModel(ra, rb, 1'b0, i[0]));
      tick();
    end
    applyStimulus(1'b1, 16'hABCD, 16'h1234, 1'b1, 1'b0);
    e = expq[0];
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_stall_valid", {31'd0, out_valid}, 32'd1);
      checkResult("bp_frozen", e);
      tick();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);
    expq.push_back(refModel(16'hABCD, 16'h1234, 1'b1, 1'b0));
    got = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (out_valid) begin
        got++;
        if (expq.size() == 0) begin
          checkOutput("bp_duplicate", 32'd1, 32'd0);
        end else begin
          checkResult("bp_drain", expq.pop_front());
        end
      end
      tick();
      if (cyc == 0) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    end
    checkOutput("bp_drain_count", got, 5);
    checkOutput("bp_left", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
